// File: rtl/bomb_scheduler_if.sv
// Bundle of the bomb scheduler's game-side signals: placement requests,
// wall maps, grant/reject responses and the bomb and flame maps.
interface bomb_scheduler_if;
    logic         i_tick;
    logic [1:0]   i_req;
    logic [7:0]   i_pos0;
    logic [7:0]   i_pos1;
    logic [2:0]   i_range0;
    logic [2:0]   i_range1;
    logic [255:0] i_wall_able;
    logic [255:0] i_wall_unable;
    logic [1:0]   o_grant;
    logic [1:0]   o_reject;
    logic [255:0] o_bomb_map;
    logic [255:0] o_explode;
    logic         o_busy;

    modport slave (
        input  i_tick, i_req, i_pos0, i_pos1, i_range0, i_range1,
               i_wall_able, i_wall_unable,
        output o_grant, o_reject, o_bomb_map, o_explode, o_busy
    );

    modport master (
        output i_tick, i_req, i_pos0, i_pos1, i_range0, i_range1,
               i_wall_able, i_wall_unable,
        input  o_grant, o_reject, o_bomb_map, o_explode, o_busy
    );
endinterface

// File: rtl/bomb_scheduler.sv
// Bomb slot pool for the 16x16 arena: two-player placement arbitration, fuses,
// and a shared engine that walks flame rays one cell per cycle.
module bomb_scheduler #(
    parameter int N_SLOTS        = 4,
    parameter int PER_PLAYER_MAX = 2,
    parameter int FUSE_TICKS     = 180,
    parameter int FLAME_TICKS    = 30
) (
    input  logic             clk,
    input  logic             rst,
    bomb_scheduler_if.slave  bus
);
    localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    typedef enum logic [1:0] {S_FREE, S_ARMED, S_PENDING} slot_e;
    typedef enum logic [1:0] {E_IDLE, E_CENTER, E_RAY} eng_e;

    slot_e        r_st   [N_SLOTS];
    logic [7:0]   r_pos  [N_SLOTS];
    logic [2:0]   r_rng  [N_SLOTS];
    logic         r_own  [N_SLOTS];
    logic [7:0]   r_fuse [N_SLOTS];

    logic [1:0]   r_grant, r_reject;
    logic         r_rr;
    logic [255:0] r_bmap, r_explode;
    logic [7:0]   r_flame;

    eng_e         r_state, w_state_n;
    logic [7:0]   r_epos;
    logic [2:0]   r_erng;
    logic [1:0]   r_dir;
    logic [3:0]   r_step;

    // ---------------- placement ----------------
    logic [1:0][7:0]    w_rpos;
    logic [1:0][2:0]    w_rrng;
    logic [1:0]         w_eval, w_ok, w_occ, w_gnt, w_rej;
    logic [1:0][SW:0]   w_cnt;
    logic [1:0][SW-1:0] w_gslot;
    logic [SW-1:0]      w_f0, w_f1;
    logic               w_f0v, w_f1v, w_hp, w_lp;
    logic [255:0]       w_bmap_n;

    assign w_rpos[0] = bus.i_pos0;
    assign w_rpos[1] = bus.i_pos1;
    assign w_rrng[0] = (bus.i_range0 == 3'd0) ? 3'd1 : bus.i_range0;
    assign w_rrng[1] = (bus.i_range1 == 3'd0) ? 3'd1 : bus.i_range1;
    assign w_eval    = bus.i_req & ~r_grant & ~r_reject;

    always_comb begin
        w_cnt   = '0;
        w_occ   = '0;
        w_ok    = '0;
        w_f0    = '0;
        w_f1    = '0;
        w_f0v   = 1'b0;
        w_f1v   = 1'b0;
        w_gnt   = '0;
        w_gslot = '0;
        w_hp    = r_rr;
        w_lp    = ~r_rr;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (r_st[s] != S_FREE) begin
                w_cnt[r_own[s]] = w_cnt[r_own[s]] + (SW+1)'(1);
                for (int p = 0; p < 2; p++)
                    if (r_pos[s] == w_rpos[p]) w_occ[p] = 1'b1;
            end else if (!w_f0v) begin
                w_f0  = SW'(s);
                w_f0v = 1'b1;
            end else if (!w_f1v) begin
                w_f1  = SW'(s);
                w_f1v = 1'b1;
            end
        end
        // Live slots are checked alongside the registered map so a bomb granted
        // last cycle is already seen as occupying its cell.
        for (int p = 0; p < 2; p++)
            w_ok[p] = w_eval[p] && !w_occ[p] && !r_bmap[w_rpos[p]] &&
                      !bus.i_wall_able[w_rpos[p]] && !bus.i_wall_unable[w_rpos[p]] &&
                      (w_cnt[p] < (SW+1)'(PER_PLAYER_MAX));
        if (w_ok[w_hp] && w_f0v) begin
            w_gnt[w_hp]   = 1'b1;
            w_gslot[w_hp] = w_f0;
        end
        if (w_ok[w_lp]) begin
            if (w_gnt[w_hp]) begin
                if (w_f1v && (w_rpos[0] != w_rpos[1])) begin
                    w_gnt[w_lp]   = 1'b1;
                    w_gslot[w_lp] = w_f1;
                end
            end else if (w_f0v) begin
                w_gnt[w_lp]   = 1'b1;
                w_gslot[w_lp] = w_f0;
            end
        end
        w_rej = w_eval & ~w_gnt;
    end

    always_comb begin
        w_bmap_n = '0;
        for (int s = 0; s < N_SLOTS; s++)
            if (r_st[s] != S_FREE) w_bmap_n[r_pos[s]] = 1'b1;
    end

    // ---------------- propagation engine ----------------
    logic [3:0]    w_row, w_col;
    logic [7:0]    w_cand, w_cell;
    logic          w_oob, w_beyond, w_mark, w_adv, w_step_inc, w_latch, w_pend_v;
    logic [SW-1:0] w_pslot;

    assign w_row    = r_epos[7:4];
    assign w_col    = r_epos[3:0];
    assign w_beyond = r_step > {1'b0, r_erng};

    always_comb begin
        w_pslot  = '0;
        w_pend_v = 1'b0;
        for (int s = N_SLOTS-1; s >= 0; s--)
            if (r_st[s] == S_PENDING) begin
                w_pslot  = SW'(s);
                w_pend_v = 1'b1;
            end
    end

    always_comb begin
        w_cand = r_epos;
        w_oob  = 1'b0;
        case (r_dir)
            2'd0: begin
                w_oob  = r_step > w_row;
                w_cand = {w_row - r_step, w_col};
            end
            2'd1: begin
                w_oob  = ({1'b0, w_row} + {1'b0, r_step}) > 5'd15;
                w_cand = {w_row + r_step, w_col};
            end
            2'd2: begin
                w_oob  = r_step > w_col;
                w_cand = {w_row, w_col - r_step};
            end
            default: begin
                w_oob  = ({1'b0, w_col} + {1'b0, r_step}) > 5'd15;
                w_cand = {w_row, w_col + r_step};
            end
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_mark     = 1'b0;
        w_cell     = r_epos;
        w_adv      = 1'b0;
        w_step_inc = 1'b0;
        w_latch    = 1'b0;
        case (r_state)
            E_IDLE: begin
                if (w_pend_v) begin
                    w_latch   = 1'b1;
                    w_state_n = E_CENTER;
                end
            end
            E_CENTER: begin
                w_mark    = 1'b1;
                w_state_n = E_RAY;
            end
            E_RAY: begin
                w_cell = w_cand;
                if (w_oob || w_beyond || bus.i_wall_unable[w_cand]) begin
                    w_adv = 1'b1;
                end else if (bus.i_wall_able[w_cand]) begin
                    w_mark = 1'b1;
                    w_adv  = 1'b1;
                end else begin
                    w_mark     = 1'b1;
                    w_step_inc = 1'b1;
                end
                if (w_adv && (r_dir == 2'd3)) w_state_n = E_IDLE;
            end
            default: w_state_n = E_IDLE;
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                r_st[s]   <= S_FREE;
                r_pos[s]  <= '0;
                r_rng[s]  <= '0;
                r_own[s]  <= 1'b0;
                r_fuse[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (w_gnt[0] && (w_gslot[0] == SW'(s))) begin
                    r_st[s]   <= S_ARMED;
                    r_pos[s]  <= w_rpos[0];
                    r_rng[s]  <= w_rrng[0];
                    r_own[s]  <= 1'b0;
                    r_fuse[s] <= 8'(FUSE_TICKS);
                end else if (w_gnt[1] && (w_gslot[1] == SW'(s))) begin
                    r_st[s]   <= S_ARMED;
                    r_pos[s]  <= w_rpos[1];
                    r_rng[s]  <= w_rrng[1];
                    r_own[s]  <= 1'b1;
                    r_fuse[s] <= 8'(FUSE_TICKS);
                end else if (w_latch && (w_pslot == SW'(s))) begin
                    r_st[s] <= S_FREE;
                end else if (r_st[s] == S_ARMED) begin
                    // Flame reaching an armed bomb hands it to the engine's queue.
                    if (w_mark && (r_pos[s] == w_cell)) begin
                        r_st[s] <= S_PENDING;
                    end else if (bus.i_tick) begin
                        r_fuse[s] <= r_fuse[s] - 8'd1;
                        if (r_fuse[s] == 8'd1) r_st[s] <= S_PENDING;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= '0;
            r_reject  <= '0;
            r_rr      <= 1'b0;
            r_bmap    <= '0;
            r_state   <= E_IDLE;
            r_epos    <= '0;
            r_erng    <= '0;
            r_dir     <= '0;
            r_step    <= '0;
            r_flame   <= '0;
            r_explode <= '0;
        end else begin
            r_grant <= w_gnt;
            r_reject <= w_rej;
            if (&w_eval) r_rr <= ~r_rr;
            r_bmap  <= w_bmap_n;
            r_state <= w_state_n;
            if (w_latch) begin
                r_epos <= r_pos[w_pslot];
                r_erng <= r_rng[w_pslot];
            end
            if (r_state == E_CENTER || w_adv) begin
                r_dir  <= (r_state == E_CENTER) ? 2'd0 : r_dir + 2'd1;
                r_step <= 4'd1;
            end else if (w_step_inc) begin
                r_step <= r_step + 4'd1;
            end
            if (w_adv && (r_dir == 2'd3))
                r_flame <= 8'(FLAME_TICKS);
            else if ((r_state == E_IDLE) && (r_flame != 8'd0) && bus.i_tick)
                r_flame <= r_flame - 8'd1;
            // Marks only happen while busy, clears only in IDLE, so they never collide.
            if (w_mark)
                r_explode[w_cell] <= 1'b1;
            else if ((r_state == E_IDLE) && (r_flame == 8'd1) && bus.i_tick)
                r_explode <= '0;
        end
    end

    assign bus.o_grant    = r_grant;
    assign bus.o_reject   = r_reject;
    assign bus.o_bomb_map = r_bmap;
    assign bus.o_explode  = r_explode;
    assign bus.o_busy     = (r_state != E_IDLE);

endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
- Owns every live bomb on the 16x16 arena. Arbitrates placement requests from two players, runs a fuse per bomb, and computes flame coverage one cell per cycle through a single shared propagation engine.
- Drives the 256-bit explode vector consumed by the wall-state block and the display.
- Cell index = row*16 + col; col = idx[3:0], row = idx[7:4].

Parameters:
- N_SLOTS, 4, total bomb slots (slot index width 2).
- PER_PLAYER_MAX, 2, max armed+pending bombs owned by one player.
- FUSE_TICKS, 180, game ticks from placement to detonation (8-bit counter, 1..255).
- FLAME_TICKS, 30, game ticks the flame map stays visible after the last propagation ends (8-bit).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  one-cycle game-tick strobe
- i_req  in  2  placement request, bit p = player p, level
- i_pos0  in  8  player 0 requested cell
- i_pos1  in  8  player 1 requested cell
- i_range0  in  3  player 0 flame range, 1..7 (0 treated as 1)
- i_range1  in  3  player 1 flame range
- i_wall_able  in  256  breakable wall present per cell
- i_wall_unable  in  256  unbreakable wall present per cell
- o_grant  out  2  one-cycle pulse, placement accepted
- o_reject  out  2  one-cycle pulse, placement refused
- o_bomb_map  out  256  cell holds an ARMED or PENDING bomb
- o_explode  out  256  flame map
- o_busy  out  1  propagation engine not IDLE

Behaviour:
- Reset: all slots FREE; o_grant, o_reject, o_bomb_map, o_explode = 0; o_busy = 0; engine IDLE; flame counter 0; round-robin pointer = player 0.
- Slot state: FREE / ARMED / PENDING. Fields: pos[7:0], range[2:0], owner, fuse[7:0].
- Placement:
  - A request is evaluated in a cycle with i_req[p]=1 and o_grant[p]=o_reject[p]=0.
  - Response is registered, 1-cycle latency, exactly one of grant/reject. The requester drops req after the response.
  - Reject if any of: cell already in o_bomb_map; i_wall_able or i_wall_unable set at the cell; no FREE slot; owner already has PER_PLAYER_MAX live slots.
  - Grant loads the lowest-index FREE slot: ARMED, fuse = FUSE_TICKS.
- Simultaneous requests:
  - Round-robin player takes priority; the pointer toggles after any cycle in which both are evaluated.
  - Same cell: loser rejected.
  - Only one FREE slot: loser rejected.
  - Otherwise both are granted into distinct slots.
- Fuse: on i_tick, each ARMED slot decrements. A slot ticking from 1 to 0 becomes PENDING. Ticks do not affect PENDING slots.
- Engine FSM: IDLE -> CENTER -> RAY -> IDLE.
  - IDLE: if any slot is PENDING, latch the lowest-index one (pos, range), set that slot FREE, go CENTER.
  - CENTER: set o_explode[pos]; dir = up; step = 1; go RAY.
  - RAY, one cell per cycle, dir order up, down, left, right. Candidate cell = pos moved step cells in dir.
    - Out of grid (row/col would wrap), or step > range: advance dir.
    - i_wall_unable at candidate: do not mark; advance dir.
    - i_wall_able at candidate: mark; advance dir.
    - Otherwise: mark; step++.
    - Advancing past right: IDLE, flame counter = FLAME_TICKS.
- Chain reaction: marking (CENTER or RAY) a cell that holds an ARMED slot sets that slot PENDING the next cycle. It detonates in a later IDLE pass. Worst-case latency per bomb = 1 + 4*(range+1) cycles.
- Flame clear: in IDLE with counter > 0, i_tick decrements; the transition to 0 clears all of o_explode. Counter is not decremented while the engine is busy. Overlapping detonations accumulate (OR) into o_explode.
- o_bomb_map is registered from slot state, updated the cycle after a slot changes.
- Placement on a cell currently in o_explode is allowed.
- Reset mid-propagation aborts immediately to reset values.

Test Plan:
- FUSE_TICKS=3, empty walls; player 0 requests 0x11, range 2 -> o_grant[0] the next cycle. o_bomb_map[0x11]=1. After the 3rd tick the engine runs; o_explode = {0x11, 0x01, 0x21, 0x31, 0x10, 0x12, 0x13}; o_bomb_map[0x11]=0. After FLAME_TICKS more ticks, o_explode = 0.
- Bomb at 0x55, range 3; i_wall_able[0x35]=1, i_wall_unable[0x56]=1 -> 0x45 and 0x35 marked, 0x25 not; right ray marks nothing; down 0x65/0x75/0x85, left 0x54/0x53/0x52 marked.
- Both players request 0x20 in the same cycle after reset -> o_grant=2'b01, o_reject=2'b10. Repeat on another cell -> o_grant=2'b10, o_reject=2'b01 (pointer toggled).
- Player 0 places 2 bombs, then a 3rd -> reject (PER_PLAYER_MAX). Player 1 fills the remaining slots, then requests again -> reject (no FREE slot). Request onto a wall cell -> reject.
- Bomb A at 0x40, range 2, fuse 3; bomb B at 0x42, fuse 100 -> B detonates immediately after A's propagation; o_explode includes 0x43 and 0x44; o_busy stays high back-to-back except a single IDLE cycle.
- Assert rst while o_busy=1 -> all outputs 0 asynchronously; after release, a new placement is granted normally.
